// File: rtl/timestamp_pkg.sv
// Shared defaults and width helpers for the hh:mm:ss timestamp counter.
package timestamp_pkg;

  localparam int DEF_CLK_PER_TICK = 1000;
  localparam int DEF_SEC_MAX      = 59;
  localparam int DEF_MIN_MAX      = 59;
  localparam int DEF_HOUR_MAX     = 23;
  localparam int DEF_FIELD_W      = 6;
  localparam int DEF_HOUR_W       = 5;

  // Bits needed to hold 0..v-1.
  function automatic int clog2(input int v);
    int r;
    int x;
    r = 0;
    x = v - 1;
    while (x > 0) begin
      r = r + 1;
      x = x >> 1;
    end
    return r;
  endfunction

  // Prescaler width, never zero so a divide-by-1 still has a register.
  function automatic int pre_width(input int v);
    return (clog2(v) < 1) ? 1 : clog2(v);
  endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Divides the enabled clock into one-cycle seconds ticks; frozen while en is low.
module tick_prescaler
  import timestamp_pkg::*;
#(
  parameter int CLK_PER_TICK = DEF_CLK_PER_TICK
) (
  input  logic clk,
  input  logic reset_n,
  input  logic en,
  input  logic clear,
  output logic tick
);

  localparam int PW = pre_width(CLK_PER_TICK);
  localparam logic [PW-1:0] PRE_LAST = PW'(CLK_PER_TICK - 1);

  logic [PW-1:0] pre;

  assign tick = en && (pre == PRE_LAST);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pre <= '0;
    end else if (clear) begin
      pre <= '0;
    end else if (en) begin
      pre <= tick ? '0 : pre + 1'b1;
    end
  end

endmodule

// File: rtl/timestamp_counter.sv
// Elapsed-time counter with load/clear, sticky rollover flag and a req/ack snapshot register.
// Snapshot handshake: snap_req is accepted when snap_valid=0 or snap_ack is high in the same cycle;
// the snapshot is held with snap_valid=1 until a cycle with snap_ack=1 (and no new request).
module timestamp_counter
  import timestamp_pkg::*;
#(
  parameter int CLK_PER_TICK = DEF_CLK_PER_TICK,
  parameter int SEC_MAX      = DEF_SEC_MAX,
  parameter int MIN_MAX      = DEF_MIN_MAX,
  parameter int HOUR_MAX     = DEF_HOUR_MAX,
  parameter int FIELD_W      = DEF_FIELD_W,
  parameter int HOUR_W       = DEF_HOUR_W
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               en,
  input  logic               clear,
  input  logic               load,
  input  logic [FIELD_W-1:0] ld_sec,
  input  logic [FIELD_W-1:0] ld_min,
  input  logic [HOUR_W-1:0]  ld_hour,
  input  logic               rst_ovf,
  input  logic               snap_req,
  input  logic               snap_ack,
  output logic [FIELD_W-1:0] sec,
  output logic [FIELD_W-1:0] min,
  output logic [HOUR_W-1:0]  hour,
  output logic               sec_pulse,
  output logic               wrap_pulse,
  output logic               ovf,
  output logic [FIELD_W-1:0] snap_sec,
  output logic [FIELD_W-1:0] snap_min,
  output logic [HOUR_W-1:0]  snap_hour,
  output logic               snap_valid
);

  localparam logic [FIELD_W-1:0] SEC_LAST  = FIELD_W'(SEC_MAX);
  localparam logic [FIELD_W-1:0] MIN_LAST  = FIELD_W'(MIN_MAX);
  localparam logic [HOUR_W-1:0]  HOUR_LAST = HOUR_W'(HOUR_MAX);

  logic               tick;
  logic [FIELD_W-1:0] sec_n;
  logic [FIELD_W-1:0] min_n;
  logic [HOUR_W-1:0]  hour_n;
  logic               sec_pulse_n;
  logic               wrap_n;
  logic               snap_cap;
  logic               snap_valid_n;

  // Load also restarts the prescaler so a loaded time gets a full second.
  tick_prescaler #(
    .CLK_PER_TICK(CLK_PER_TICK)
  ) u_prescaler (
    .clk     (clk),
    .reset_n (reset_n),
    .en      (en),
    .clear   (clear | load),
    .tick    (tick)
  );

  always_comb begin
    sec_n       = sec;
    min_n       = min;
    hour_n      = hour;
    sec_pulse_n = 1'b0;
    wrap_n      = 1'b0;
    if (clear) begin
      sec_n  = '0;
      min_n  = '0;
      hour_n = '0;
    end else if (load) begin
      sec_n  = (ld_sec  > SEC_LAST)  ? '0 : ld_sec;
      min_n  = (ld_min  > MIN_LAST)  ? '0 : ld_min;
      hour_n = (ld_hour > HOUR_LAST) ? '0 : ld_hour;
    end else if (tick) begin
      sec_pulse_n = 1'b1;
      if (sec < SEC_LAST) begin
        sec_n = sec + 1'b1;
      end else begin
        sec_n = '0;
        if (min < MIN_LAST) begin
          min_n = min + 1'b1;
        end else begin
          min_n = '0;
          if (hour < HOUR_LAST) begin
            hour_n = hour + 1'b1;
          end else begin
            hour_n = '0;
            wrap_n = 1'b1;
          end
        end
      end
    end
  end

  always_comb begin
    snap_cap     = snap_req && (!snap_valid || snap_ack);
    snap_valid_n = snap_valid;
    if (snap_cap) begin
      snap_valid_n = 1'b1;
    end else if (snap_ack) begin
      snap_valid_n = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sec        <= '0;
      min        <= '0;
      hour       <= '0;
      sec_pulse  <= 1'b0;
      wrap_pulse <= 1'b0;
      ovf        <= 1'b0;
    end else begin
      sec        <= sec_n;
      min        <= min_n;
      hour       <= hour_n;
      sec_pulse  <= sec_pulse_n;
      wrap_pulse <= wrap_n;
      // A rollover in the same cycle as rst_ovf must not be lost.
      if (wrap_n) begin
        ovf <= 1'b1;
      end else if (rst_ovf) begin
        ovf <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      snap_sec   <= '0;
      snap_min   <= '0;
      snap_hour  <= '0;
      snap_valid <= 1'b0;
    end else begin
      snap_valid <= snap_valid_n;
      if (snap_cap) begin
        snap_sec  <= sec;
        snap_min  <= min;
        snap_hour <= hour;
      end
    end
  end

endmodule
